vend_sequencer: RTL and testbench

//   Top-level controller for the vending datapath: accumulates coin credit, accepts a product

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_sequencer_if.sv | 27 ++
 rtl/vend_change_gen.sv | 21 ++
 rtl/vend_sequencer.sv | 142 ++++++++++++++
 tb/tb_vend_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending sequencer: FSM states, change-coin codes and item encodings.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_4    = 2'b11;

  localparam logic ITEM_A = 1'b0;
  localparam logic ITEM_B = 1'b1;

  function automatic logic [2:0] coin_weight(input logic [1:0] code);
    case (code)
      COIN_1:  return 3'd1;
      COIN_2:  return 3'd2;
      COIN_4:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin/select inputs, dispenser handshake and change handshake of the vending sequencer.
interface vend_sequencer_if #(parameter int CREDIT_W = 4);
  logic                d1;
  logic                d2;
  logic                d3;
  logic                sel_a;
  logic                sel_b;
  logic                cancel;
  logic                vend_req;
  logic                vend_item;
  logic                vend_ack;
  logic                chg_valid;
  logic [1:0]          chg_coin;
  logic                chg_ready;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output d1, d2, d3, sel_a, sel_b, cancel, vend_ack, chg_ready,
    input  vend_req, vend_item, chg_valid, chg_coin, credit, busy
  );

  modport slave (
    input  d1, d2, d3, sel_a, sel_b, cancel, vend_ack, chg_ready,
    output vend_req, vend_item, chg_valid, chg_coin, credit, busy
  );
endinterface

// File: rtl/vend_change_gen.sv
// Greedy change denomination: largest coin that does not exceed the remaining credit.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin
);

  always_comb begin
    o_coin = COIN_NONE;
    if (int'(i_credit) >= 4)
      o_coin = COIN_4;
    else if (int'(i_credit) >= 2)
      o_coin = COIN_2;
    else if (int'(i_credit) >= 1)
      o_coin = COIN_1;
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: collects coin credit, vends one item per selection, then pays change coin by coin.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_A  = 3,
  parameter int PRICE_B  = 5,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           rst,
  vend_sequencer_if.slave vend_bus
);

  localparam int MAX_CREDIT = 2**CREDIT_W - 1;
  localparam int SUM_W      = CREDIT_W + 1;
  localparam int TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              r_state, w_state_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_next;
  logic [TIMER_W-1:0]  r_timer, w_timer_next;
  logic                r_vend_req, w_vend_req_next;
  logic                r_vend_item, w_vend_item_next;
  logic                r_chg_valid, w_chg_valid_next;
  logic [1:0]          r_chg_coin, w_chg_coin_next;
  logic                r_busy, w_busy_next;

  logic [2:0]          w_coin_wt;
  logic [SUM_W-1:0]    w_coin_sum;
  logic                w_coin_ok;
  logic                w_sel_a_ok;
  logic                w_sel_b_ok;
  logic [1:0]          w_greedy_coin;

  // Only one coin per cycle counts; d1 wins over d2 wins over d3.
  always_comb begin
    w_coin_wt = 3'd0;
    if (vend_bus.d1)
      w_coin_wt = 3'd1;
    else if (vend_bus.d2)
      w_coin_wt = 3'd2;
    else if (vend_bus.d3)
      w_coin_wt = 3'd4;
  end

  assign w_coin_sum = {1'b0, r_credit} + SUM_W'(w_coin_wt);
  assign w_coin_ok  = (w_coin_wt != 3'd0) && (w_coin_sum <= SUM_W'(MAX_CREDIT));
  assign w_sel_a_ok = vend_bus.sel_a && (r_credit >= CREDIT_W'(PRICE_A));
  assign w_sel_b_ok = !vend_bus.sel_a && vend_bus.sel_b && (r_credit >= CREDIT_W'(PRICE_B));

  vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .i_credit (w_credit_next),
    .o_coin   (w_greedy_coin)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_credit    <= '0;
      r_timer     <= '0;
      r_vend_req  <= 1'b0;
      r_vend_item <= 1'b0;
      r_chg_valid <= 1'b0;
      r_chg_coin  <= COIN_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_credit    <= w_credit_next;
      r_timer     <= w_timer_next;
      r_vend_req  <= w_vend_req_next;
      r_vend_item <= w_vend_item_next;
      r_chg_valid <= w_chg_valid_next;
      r_chg_coin  <= w_chg_coin_next;
      r_busy      <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_timer_next  = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_coin_ok) begin
          w_credit_next = w_coin_sum[CREDIT_W-1:0];
          w_timer_next  = '0;
          w_state_next  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (vend_bus.cancel) begin
          w_state_next = ST_CHANGE;
        end else if (w_sel_a_ok) begin
          w_credit_next = r_credit - CREDIT_W'(PRICE_A);
          w_state_next  = ST_VEND;
        end else if (w_sel_b_ok) begin
          w_credit_next = r_credit - CREDIT_W'(PRICE_B);
          w_state_next  = ST_VEND;
        end else if (w_coin_ok) begin
          w_credit_next = w_coin_sum[CREDIT_W-1:0];
          w_timer_next  = '0;
        end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
          w_timer_next = '0;
          w_state_next = ST_CHANGE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      ST_VEND: begin
        if (vend_bus.vend_ack && r_vend_req)
          w_state_next = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (r_chg_valid && vend_bus.chg_ready) begin
          w_credit_next = r_credit - CREDIT_W'(coin_weight(r_chg_coin));
          if (w_credit_next == '0)
            w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they appear registered with it.
  always_comb begin
    w_vend_req_next  = (w_state_next == ST_VEND);
    w_vend_item_next = r_vend_item;
    if (r_state == ST_COLLECT && w_state_next == ST_VEND)
      w_vend_item_next = w_sel_a_ok ? ITEM_A : ITEM_B;
    w_chg_valid_next = (w_state_next == ST_CHANGE);
    w_chg_coin_next  = w_chg_valid_next ? w_greedy_coin : COIN_NONE;
    w_busy_next      = (w_state_next == ST_VEND) || (w_state_next == ST_CHANGE);
  end

  assign vend_bus.vend_req  = r_vend_req;
  assign vend_bus.vend_item = r_vend_item;
  assign vend_bus.chg_valid = r_chg_valid;
  assign vend_bus.chg_coin  = r_chg_coin;
  assign vend_bus.credit    = r_credit;
  assign vend_bus.busy      = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed-vector bench for vend_sequencer with hand-computed expectations.
module tb_vend_sequencer;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  vend_sequencer_if #(.CREDIT_W(4)) bus ();

  vend_sequencer #(
    .PRICE_A  (3),
    .PRICE_B  (5),
    .CREDIT_W (4),
    .TIMEOUT  (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vend_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("vec %0d %s: %0h ok", n_vec, tag, obs);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int which);
    bus.d1 = (which == 1);
    bus.d2 = (which == 2);
    bus.d3 = (which == 4);
    tick();
    bus.d1 = 1'b0;
    bus.d2 = 1'b0;
    bus.d3 = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.d1 = 1'b0; bus.d2 = 1'b0; bus.d3 = 1'b0;
    bus.sel_a = 1'b0; bus.sel_b = 1'b0; bus.cancel = 1'b0;
    bus.vend_ack = 1'b0; bus.chg_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_credit", 32'(bus.credit), 0);
    check_eq("rst_vend_req", 32'(bus.vend_req), 0);
    check_eq("rst_chg_valid", 32'(bus.chg_valid), 0);
    check_eq("rst_chg_coin", 32'(bus.chg_coin), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    rst = 1'b1;
    tick();

    // d2,d2 then buy A, change of one unit
    coin(2);
    check_eq("a_credit2", 32'(bus.credit), 2);
    coin(2);
    check_eq("a_credit4", 32'(bus.credit), 4);
    bus.sel_a = 1'b1; tick(); bus.sel_a = 1'b0;
    check_eq("a_vend_req", 32'(bus.vend_req), 1);
    check_eq("a_vend_item", 32'(bus.vend_item), 0);
    check_eq("a_credit1", 32'(bus.credit), 1);
    check_eq("a_busy", 32'(bus.busy), 1);
    tick();
    check_eq("a_req_held", 32'(bus.vend_req), 1);
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
    check_eq("a_req_drop", 32'(bus.vend_req), 0);
    check_eq("a_chg_valid", 32'(bus.chg_valid), 1);
    check_eq("a_chg_coin", 32'(bus.chg_coin), 1);
    bus.chg_ready = 1'b1; tick(); bus.chg_ready = 1'b0;
    check_eq("a_end_valid", 32'(bus.chg_valid), 0);
    check_eq("a_end_coin", 32'(bus.chg_coin), 0);
    check_eq("a_end_credit", 32'(bus.credit), 0);
    check_eq("a_end_busy", 32'(bus.busy), 0);

    // d3,d3 then buy B, change 2+1 with back-pressure
    coin(4);
    coin(4);
    check_eq("b_credit8", 32'(bus.credit), 8);
    bus.sel_b = 1'b1; tick(); bus.sel_b = 1'b0;
    check_eq("b_vend_req", 32'(bus.vend_req), 1);
    check_eq("b_vend_item", 32'(bus.vend_item), 1);
    check_eq("b_credit3", 32'(bus.credit), 3);
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
    check_eq("b_coin2", 32'(bus.chg_coin), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("b_coin2_held", 32'(bus.chg_coin), 2);
      check_eq("b_valid_held", 32'(bus.chg_valid), 1);
    end
    bus.chg_ready = 1'b1; tick();
    check_eq("b_credit1", 32'(bus.credit), 1);
    check_eq("b_coin1", 32'(bus.chg_coin), 1);
    tick(); bus.chg_ready = 1'b0;
    check_eq("b_end_credit", 32'(bus.credit), 0);
    check_eq("b_end_valid", 32'(bus.chg_valid), 0);

    // unaffordable A ignored, then cancel refunds
    coin(1);
    bus.sel_a = 1'b1; tick(); bus.sel_a = 1'b0;
    check_eq("c_no_vend", 32'(bus.vend_req), 0);
    check_eq("c_credit1", 32'(bus.credit), 1);
    check_eq("c_not_busy", 32'(bus.busy), 0);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    check_eq("c_chg_valid", 32'(bus.chg_valid), 1);
    check_eq("c_chg_coin", 32'(bus.chg_coin), 1);
    bus.chg_ready = 1'b1; tick(); bus.chg_ready = 1'b0;
    check_eq("c_end_valid", 32'(bus.chg_valid), 0);
    check_eq("c_end_credit", 32'(bus.credit), 0);

    // timeout: 15 idle cycles after the coin triggers a refund
    coin(1);
    for (int i = 0; i < 14; i++) tick();
    check_eq("t_before", 32'(bus.chg_valid), 0);
    tick();
    check_eq("t_refund_valid", 32'(bus.chg_valid), 1);
    check_eq("t_refund_coin", 32'(bus.chg_coin), 1);
    coin(4);
    check_eq("t_coin_ignored", 32'(bus.credit), 1);
    check_eq("t_coin_held", 32'(bus.chg_coin), 1);
    bus.chg_ready = 1'b1; tick(); bus.chg_ready = 1'b0;
    check_eq("t_end_credit", 32'(bus.credit), 0);
    check_eq("t_end_valid", 32'(bus.chg_valid), 0);

    // overflow rejection at 13, then drain 4,4,4,1
    coin(4); coin(4); coin(4); coin(1);
    check_eq("o_credit13", 32'(bus.credit), 13);
    coin(4);
    check_eq("o_rejected", 32'(bus.credit), 13);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    check_eq("o_coin4", 32'(bus.chg_coin), 3);
    bus.chg_ready = 1'b1;
    tick();
    check_eq("o_credit9", 32'(bus.credit), 9);
    tick();
    check_eq("o_credit5", 32'(bus.credit), 5);
    tick();
    check_eq("o_credit1", 32'(bus.credit), 1);
    check_eq("o_last_coin", 32'(bus.chg_coin), 1);
    tick();
    bus.chg_ready = 1'b0;
    check_eq("o_end_credit", 32'(bus.credit), 0);

    // d1 and d3 together: only d1 counts
    bus.d1 = 1'b1; bus.d3 = 1'b1; tick(); bus.d1 = 1'b0; bus.d3 = 1'b0;
    check_eq("p_credit1", 32'(bus.credit), 1);

    // asynchronous reset while change is being offered
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    check_eq("r_pre_valid", 32'(bus.chg_valid), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("r_async_valid", 32'(bus.chg_valid), 0);
    check_eq("r_async_coin", 32'(bus.chg_coin), 0);
    check_eq("r_async_credit", 32'(bus.credit), 0);
    check_eq("r_async_busy", 32'(bus.busy), 0);
    tick();
    rst = 1'b1;
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    check_eq("r_idle_cancel", 32'(bus.chg_valid), 0);
    coin(2);
    check_eq("r_idle_coin", 32'(bus.credit), 2);
    check_eq("r_idle_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
